reg_number_assembler: RTL and testbench
=======================================

// Module: reg_number_assembler
// PURPOSE
//  Assembles a multi-digit number from a stream of input samples (keypad/UART/port data) under
//  processor control, and exposes it at a fixed memory-mapped address. It replaces the single-
//  mode byte shifter with configurable digit width and depth, and a decimal-accumulate mode.
//  It adds change detection, commit/ready handshaking and overflow/error reporting.
//  It sits between the input peripheral and the CPU data bus.
// PARAMETERS
//  DATA_W      32           width of x and number
//  DIGIT_W     8            bits taken from x per captured sample (MODE 0)
//  MAX_DIGITS  4            digits held before FULL
//  MODE        0            0 = shift-concatenate, 1 = decimal accumulate (number*10 + x[3:0])
//  ADDR_W      32           width of direction
//  ADDR        32'h00400004 memory-mapped address driven on direction
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  controller   in   2        command: 0 CLEAR, 1 HOLD, 2 CAPTURE, 3 COMMIT
//  x            in   DATA_W   input sample
//  flag         in   1        inhibit; when 1, CAPTURE is ignored
//  number       out  DATA_W   assembled value
//  direction    out  ADDR_W   constant ADDR
//  digit_count  out  $clog2(MAX_DIGITS+1)  digits currently held
//  ready        out  1        number committed and stable
//  commit_pulse out  1        one-cycle strobe on entering DONE
//  error        out  1        sticky: overflow or invalid decimal digit
// BEHAVIOUR
//  - Reset (async, rst_n=0): number=0, digit_count=0, ready=0, commit_pulse=0, error=0,
//    last_vld=0, state=EMPTY. Reset takes effect immediately, without waiting for a clock edge.
//    direction=ADDR at all times.
//  - Capture event (registered): controller==CAPTURE & ~flag & (~last_vld | x!=last_x).
//    On every capture event: last_x<=x and last_vld<=1.
//  - Shift update, MODE 0: number <= {number[DATA_W-DIGIT_W-1:0], x[DIGIT_W-1:0]}.
//  - Decimal update, MODE 1: number <= number*10 + x[3:0].
//    If x[3:0]>9, the digit is dropped and error<=1; last_x still updates.
//  - number, digit_count and ready update on the edge where the event is sampled.
//    They are visible one cycle later; there is no other latency.
//  - States and transitions:
//    EMPTY   (count=0)  capture -> COLLECT; COMMIT ignored.
//    COLLECT            capture -> count+1, number updated; count reaching MAX_DIGITS -> FULL;
//                       COMMIT -> DONE.
//    FULL               capture -> sample dropped, number unchanged, error<=1; COMMIT -> DONE.
//    DONE               ready=1; CAPTURE and COMMIT ignored; only CLEAR leaves.
//  - CLEAR from any state: next edge gives state=EMPTY, number=0, count=0, ready=0, error=0,
//    last_vld=0.
//  - HOLD: no state change.
//  - commit_pulse: high for exactly one cycle, on entering DONE.
//  - Width rules, checked at elaboration:
//    MODE 0 requires MAX_DIGITS*DIGIT_W <= DATA_W.
//    MODE 1 requires 10**MAX_DIGITS-1 < 2**DATA_W, so accumulation can never wrap.
//  - controller is a single code, so CLEAR, CAPTURE and COMMIT can never occur together.
//    rst_n has priority over everything.
// STRUCTURE
//  - Package reg_op_pkg:
//    controller codes CMD_CLEAR/CMD_HOLD/CMD_CAPTURE/CMD_COMMIT;
//    state enum EMPTY/COLLECT/FULL/DONE; mode constants MODE_SHIFT/MODE_DEC.
//  - Sub-module digit_accumulator (combinational):
//    inputs number, x, MODE; outputs next_number and digit_ok.
//  - Top level holds the FSM, counter, last_x/last_vld and sticky flags.
// TESTING
//  1 Reset: rst_n=0 -> number=0, count=0, ready=0, error=0, direction=32'h00400004.
//  2 MODE0, DIGIT_W=8, MAX=4: CAPTURE x=0x41,0x42,0x42,0x43
//    -> number=0x00414243, count=3 (repeat ignored).
//    Then COMMIT -> ready=1, commit_pulse high for 1 cycle.
//  3 MODE0: CAPTURE 5 distinct values 0x01..0x05 -> number=0x01020304, state FULL, error=1.
//  4 MODE1: CAPTURE 1,2,3, COMMIT -> number=123, ready=1.
//    Then CLEAR, CAPTURE 0xC -> number=0, error=1.
//  5 flag=1, CAPTURE x=0x55 -> no change. Then flag=0 -> captured.
//    CLEAR, then CAPTURE 0x55 again -> accepted (last_vld cleared), count=1.
//  6 rst_n driven low mid-COLLECT between clock edges -> outputs zero immediately.
//    After release, EMPTY.

Source files
------------

// File: rtl/reg_op_pkg.sv
// Shared command codes, FSM states, mode selectors and elaboration helpers
// for the memory-mapped number assembler.
package reg_op_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR   = 2'd0,
    CMD_HOLD    = 2'd1,
    CMD_CAPTURE = 2'd2,
    CMD_COMMIT  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned MODE_SHIFT = 0;
  localparam int unsigned MODE_DEC   = 1;

  // 10**n in 64 bits, used to size-check decimal accumulation
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Combinational next-value datapath: shift-concatenate a digit or
// accumulate a decimal digit, flagging decimal digits above 9.
module digit_accumulator
  import reg_op_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIGIT_W = 8,
  parameter int unsigned MODE    = MODE_SHIFT
) (
  input  logic [DATA_W-1:0] number,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] next_number,
  output logic              digit_ok
);

  // Only a slice of x feeds either mode; the rest is intentionally ignored.
  logic unused_x;
  assign unused_x = ^x;

  always_comb begin
    next_number = number;
    digit_ok    = 1'b1;
    if (MODE == MODE_DEC) begin
      digit_ok    = (x[3:0] <= 4'd9);
      next_number = (number << 3) + (number << 1) + DATA_W'(x[3:0]);
    end else begin
      next_number = (number << DIGIT_W) | DATA_W'(x[DIGIT_W-1:0]);
    end
  end

endmodule

// File: rtl/reg_number_assembler.sv
// Processor-controlled multi-digit number assembler with change detection,
// commit handshake and sticky error, exposed at a fixed bus address.
module reg_number_assembler
  import reg_op_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DIGIT_W    = 8,
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MODE       = MODE_SHIFT,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR = 32'h00400004
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        controller,
  input  logic [DATA_W-1:0]                 x,
  input  logic                              flag,
  output logic [DATA_W-1:0]                 number,
  output logic [ADDR_W-1:0]                 direction,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  output logic                              ready,
  output logic                              commit_pulse,
  output logic                              error
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  // Reject configurations whose digits could spill out of the number register
  if (MODE == MODE_SHIFT) begin : g_chk_shift
    if (MAX_DIGITS * DIGIT_W > DATA_W) begin : g_bad
      $error("MAX_DIGITS*DIGIT_W exceeds DATA_W");
    end
  end else begin : g_chk_dec
    if (DATA_W < 64) begin : g_narrow
      if (pow10(MAX_DIGITS) - 64'd1 >= (64'd1 << DATA_W)) begin : g_bad
        $error("decimal accumulation could wrap DATA_W");
      end
    end
  end

  state_e             state, state_n;
  logic [DATA_W-1:0]  number_n, acc_next, last_x, last_x_n;
  logic [CNT_W-1:0]   count_n, count_inc;
  logic               last_vld, last_vld_n, error_n, ready_n, commit_n;
  logic               digit_ok, capture_c;

  assign direction = ADDR;
  assign count_inc = digit_count + CNT_W'(1);

  digit_accumulator #(
    .DATA_W  (DATA_W),
    .DIGIT_W (DIGIT_W),
    .MODE    (MODE)
  ) u_acc (
    .number      (number),
    .x           (x),
    .next_number (acc_next),
    .digit_ok    (digit_ok)
  );

  // A capture is a new (or first) sample presented with CAPTURE while not inhibited
  assign capture_c = (cmd_e'(controller) == CMD_CAPTURE) && !flag &&
                     (!last_vld || (x != last_x));

  always_comb begin
    state_n    = state;
    number_n   = number;
    count_n    = digit_count;
    error_n    = error;
    last_x_n   = last_x;
    last_vld_n = last_vld;

    if (capture_c) begin
      last_x_n   = x;
      last_vld_n = 1'b1;
    end

    case (cmd_e'(controller))
      CMD_CLEAR: begin
        state_n    = EMPTY;
        number_n   = '0;
        count_n    = '0;
        error_n    = 1'b0;
        last_vld_n = 1'b0;
      end
      CMD_CAPTURE: begin
        if (capture_c) begin
          case (state)
            EMPTY, COLLECT: begin
              if (!digit_ok) begin
                error_n = 1'b1;
              end else begin
                number_n = acc_next;
                count_n  = count_inc;
                state_n  = (count_inc == CNT_W'(MAX_DIGITS)) ? FULL : COLLECT;
              end
            end
            FULL:    error_n = 1'b1;
            default: ;
          endcase
        end
      end
      CMD_COMMIT: begin
        if (state == COLLECT || state == FULL) state_n = DONE;
      end
      default: ;
    endcase

    ready_n  = (state_n == DONE);
    commit_n = (state_n == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      number       <= '0;
      digit_count  <= '0;
      ready        <= 1'b0;
      commit_pulse <= 1'b0;
      error        <= 1'b0;
      last_x       <= '0;
      last_vld     <= 1'b0;
    end else begin
      state        <= state_n;
      number       <= number_n;
      digit_count  <= count_n;
      ready        <= ready_n;
      commit_pulse <= commit_n;
      error        <= error_n;
      last_x       <= last_x_n;
      last_vld     <= last_vld_n;
    end
  end

endmodule

// File: tb/tb_reg_number_assembler.sv
// Directed bench for reg_number_assembler: one shift-mode and one
// decimal-mode instance driven from a shared stimulus sequence.
module tb_reg_number_assembler;
  import reg_op_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  controller;
  logic [31:0] x;
  logic        flag;

  logic [31:0] num0, num1, dir0, dir1;
  logic [2:0]  cnt0, cnt1;
  logic        rdy0, rdy1, cp0, cp1, err0, err1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_number_assembler #(.MODE(MODE_SHIFT)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .controller(controller), .x(x), .flag(flag),
    .number(num0), .direction(dir0), .digit_count(cnt0), .ready(rdy0),
    .commit_pulse(cp0), .error(err0)
  );

  reg_number_assembler #(.MODE(MODE_DEC)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .controller(controller), .x(x), .flag(flag),
    .number(num1), .direction(dir1), .digit_count(cnt1), .ready(rdy1),
    .commit_pulse(cp1), .error(err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command for one clock, then sample just after the edge
  task automatic step(input logic [1:0] c, input logic [31:0] v);
    controller = c;
    x          = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    controller = CMD_HOLD;
    x          = '0;
    flag       = 1'b0;

    // 1: reset values
    #12;
    check("rst_number", 64'(num0), 64'h0);
    check("rst_count", 64'(cnt0), 64'h0);
    check("rst_ready", 64'(rdy0), 64'h0);
    check("rst_error", 64'(err0), 64'h0);
    check("rst_pulse", 64'(cp0), 64'h0);
    check("rst_dir0", 64'(dir0), 64'h00400004);
    check("rst_dir1", 64'(dir1), 64'h00400004);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: shift mode with a repeated sample, then commit
    step(CMD_CAPTURE, 32'h41);
    check("t2_first_count", 64'(cnt0), 64'h1);
    check("t2_first_number", 64'(num0), 64'h41);
    step(CMD_CAPTURE, 32'h42);
    step(CMD_CAPTURE, 32'h42);
    step(CMD_CAPTURE, 32'h43);
    check("t2_number", 64'(num0), 64'h00414243);
    check("t2_count", 64'(cnt0), 64'h3);
    check("t2_error", 64'(err0), 64'h0);
    check("t2_ready_pre", 64'(rdy0), 64'h0);
    step(CMD_COMMIT, 32'h43);
    check("t2_ready", 64'(rdy0), 64'h1);
    check("t2_pulse", 64'(cp0), 64'h1);
    step(CMD_CAPTURE, 32'h44);
    check("t2_pulse_once", 64'(cp0), 64'h0);
    check("t2_ready_hold", 64'(rdy0), 64'h1);
    check("t2_done_ignores", 64'(num0), 64'h00414243);

    // 3: overflow into FULL
    step(CMD_CLEAR, 32'h0);
    check("t3_clr_number", 64'(num0), 64'h0);
    check("t3_clr_ready", 64'(rdy0), 64'h0);
    check("t3_clr_count", 64'(cnt0), 64'h0);
    step(CMD_CAPTURE, 32'h01);
    step(CMD_CAPTURE, 32'h02);
    step(CMD_CAPTURE, 32'h03);
    step(CMD_CAPTURE, 32'h04);
    check("t3_count_max", 64'(cnt0), 64'h4);
    check("t3_no_err_yet", 64'(err0), 64'h0);
    step(CMD_CAPTURE, 32'h05);
    check("t3_number", 64'(num0), 64'h01020304);
    check("t3_count", 64'(cnt0), 64'h4);
    check("t3_error", 64'(err0), 64'h1);
    step(CMD_COMMIT, 32'h05);
    check("t3_full_commit", 64'(rdy0), 64'h1);

    // 4: decimal accumulate and invalid digit
    step(CMD_CLEAR, 32'h0);
    check("t4_clr_error", 64'(err0), 64'h0);
    step(CMD_CAPTURE, 32'h1);
    step(CMD_CAPTURE, 32'h2);
    step(CMD_CAPTURE, 32'h3);
    check("t4_dec_number", 64'(num1), 64'd123);
    check("t4_dec_count", 64'(cnt1), 64'h3);
    step(CMD_COMMIT, 32'h3);
    check("t4_dec_ready", 64'(rdy1), 64'h1);
    check("t4_dec_pulse", 64'(cp1), 64'h1);
    step(CMD_CLEAR, 32'h0);
    step(CMD_CAPTURE, 32'hC);
    check("t4_bad_number", 64'(num1), 64'h0);
    check("t4_bad_error", 64'(err1), 64'h1);
    step(CMD_CAPTURE, 32'h5);
    check("t4_after_bad", 64'(num1), 64'd5);
    check("t4_err_sticky", 64'(err1), 64'h1);

    // 5: inhibit flag and last_vld clearing
    step(CMD_CLEAR, 32'h0);
    flag = 1'b1;
    step(CMD_CAPTURE, 32'h55);
    check("t5_inhibit_count", 64'(cnt0), 64'h0);
    check("t5_inhibit_number", 64'(num0), 64'h0);
    flag = 1'b0;
    step(CMD_CAPTURE, 32'h55);
    check("t5_capt_count", 64'(cnt0), 64'h1);
    check("t5_capt_number", 64'(num0), 64'h55);
    step(CMD_CLEAR, 32'h0);
    step(CMD_CAPTURE, 32'h55);
    check("t5_reaccept_count", 64'(cnt0), 64'h1);
    check("t5_reaccept_number", 64'(num0), 64'h55);

    // 6: asynchronous reset between clock edges
    step(CMD_CAPTURE, 32'h66);
    check("t6_pre_number", 64'(num0), 64'h5566);
    #3;
    controller = CMD_HOLD;
    rst_n      = 1'b0;
    #1;
    check("t6_async_number", 64'(num0), 64'h0);
    check("t6_async_count", 64'(cnt0), 64'h0);
    check("t6_async_dec", 64'(num1), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_count", 64'(cnt0), 64'h0);
    step(CMD_COMMIT, 32'h0);
    check("t6_empty_commit", 64'(rdy0), 64'h0);
    check("t6_empty_pulse", 64'(cp0), 64'h0);
    step(CMD_CAPTURE, 32'h77);
    check("t6_capture_count", 64'(cnt0), 64'h1);
    check("t6_capture_number", 64'(num0), 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
